// File: rtl/kgp_risc_datapath_pkg.sv
// KGP-RISC shared definitions: opcodes, field slices and
// the two built-in program images.
package kgp_risc_datapath_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLA  = 4'h5,
    OP_SRA  = 4'h6,
    OP_ADDI = 4'h7,
    OP_LD   = 4'h8,
    OP_ST   = 4'h9,
    OP_BEQ  = 4'hA,
    OP_BLT  = 4'hB,
    OP_BR   = 4'hC,
    OP_HALT = 4'hF
  } op_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLA,
    ALU_SRA
  } alu_op_e;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 28;
  localparam int RD_HI  = 27;
  localparam int RD_LO  = 24;
  localparam int RS_HI  = 23;
  localparam int RS_LO  = 20;
  localparam int RT_HI  = 19;
  localparam int RT_LO  = 16;
  localparam int IMM_HI = 15;

  localparam int          IMEM_DEPTH_D = 64;
  localparam logic [3:0]  SP_REG       = 4'd15;
  localparam logic [31:0] SP_INIT      = 32'd15;
  localparam logic [31:0] HALT_W       = 32'hF000_0000;

  function automatic logic [31:0] ins(
    op_e op, int rd, int rs, int rt, int imm
  );
    return {op, rd[3:0], rs[3:0], rt[3:0], imm[15:0]};
  endfunction

  // R1=a, R2=b; subtract smaller from larger until equal or zero
  localparam int GCD_LEN = 13;
  localparam logic [31:0] GCD_ROM [0:GCD_LEN-1] = '{
    ins(OP_LD,   1, 0, 0, 0),
    ins(OP_LD,   2, 0, 0, 1),
    ins(OP_BEQ,  0, 1, 0, 8),
    ins(OP_BEQ,  0, 2, 0, 6),
    ins(OP_BEQ,  0, 1, 2, 6),
    ins(OP_BLT,  0, 1, 2, 2),
    ins(OP_SUB,  1, 1, 2, 0),
    ins(OP_BR,   0, 0, 0, 2),
    ins(OP_SUB,  2, 2, 1, 0),
    ins(OP_BR,   0, 0, 0, 2),
    ins(OP_ADD,  2, 1, 0, 0),
    ins(OP_ADDI, 3, 0, 0, 1),
    ins(OP_HALT, 0, 0, 0, 0)
  };

  // R1=M, R3:R2=A:Q, R4=Q-1, R5/R6=bit31 set/clear masks,
  // R7=count, R9=1; Q shift is made logical with the masks
  localparam int BOOTH_LEN = 40;
  localparam logic [31:0] BOOTH_ROM [0:BOOTH_LEN-1] = '{
    ins(OP_LD,   1, 0, 0, 0),
    ins(OP_LD,   2, 0, 0, 1),
    ins(OP_ADD,  3, 0, 0, 0),
    ins(OP_ADD,  4, 0, 0, 0),
    ins(OP_ADDI, 9, 0, 0, 1),
    ins(OP_ADDI, 7, 0, 0, 32),
    ins(OP_ADDI, 5, 0, 0, -32768),
    ins(OP_SLA,  5, 5, 0, 0),
    ins(OP_SLA,  5, 5, 0, 0),
    ins(OP_SLA,  5, 5, 0, 0),
    ins(OP_SLA,  5, 5, 0, 0),
    ins(OP_SLA,  5, 5, 0, 0),
    ins(OP_SLA,  5, 5, 0, 0),
    ins(OP_SLA,  5, 5, 0, 0),
    ins(OP_SLA,  5, 5, 0, 0),
    ins(OP_SLA,  5, 5, 0, 0),
    ins(OP_SLA,  5, 5, 0, 0),
    ins(OP_SLA,  5, 5, 0, 0),
    ins(OP_SLA,  5, 5, 0, 0),
    ins(OP_SLA,  5, 5, 0, 0),
    ins(OP_SLA,  5, 5, 0, 0),
    ins(OP_SLA,  5, 5, 0, 0),
    ins(OP_SLA,  5, 5, 0, 0),
    ins(OP_ADDI, 6, 5, 0, -1),
    ins(OP_AND,  8, 2, 9, 0),
    ins(OP_BEQ,  0, 8, 4, 4),
    ins(OP_BEQ,  0, 8, 0, 2),
    ins(OP_SUB,  3, 3, 1, 0),
    ins(OP_BR,   0, 0, 0, 30),
    ins(OP_ADD,  3, 3, 1, 0),
    ins(OP_ADD,  4, 8, 0, 0),
    ins(OP_SRA,  2, 2, 0, 0),
    ins(OP_AND,  2, 2, 6, 0),
    ins(OP_AND,  8, 3, 9, 0),
    ins(OP_BEQ,  0, 8, 0, 1),
    ins(OP_OR,   2, 2, 5, 0),
    ins(OP_SRA,  3, 3, 0, 0),
    ins(OP_ADDI, 7, 7, 0, -1),
    ins(OP_BLT,  0, 0, 7, -15),
    ins(OP_HALT, 0, 0, 0, 0)
  };

endpackage

// File: rtl/kgp_risc_datapath_if.sv
// Datapath-to-ALU bundle: operands and op select out,
// result and compare flags back.
interface kgp_risc_datapath_if;
  import kgp_risc_datapath_pkg::*;

  alu_op_e     op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] y;
  logic        eq;
  logic        lt;

  modport master (output op, a, b, input y, eq, lt);
  modport slave  (input op, a, b, output y, eq, lt);
endinterface

// File: rtl/kgp_risc_datapath_alu.sv
// Combinational 32-bit ALU with equality and signed
// less-than flags for the branch unit.
module kgp_alu
  import kgp_risc_datapath_pkg::*;
(
  kgp_risc_datapath_if.slave alu
);

  always_comb begin
    alu.y = '0;
    case (alu.op)
      ALU_ADD: alu.y = alu.a + alu.b;
      ALU_SUB: alu.y = alu.a - alu.b;
      ALU_AND: alu.y = alu.a & alu.b;
      ALU_OR:  alu.y = alu.a | alu.b;
      ALU_XOR: alu.y = alu.a ^ alu.b;
      ALU_SLA: alu.y = {alu.a[30:0], 1'b0};
      ALU_SRA: alu.y = {alu.a[31], alu.a[31:1]};
      default: alu.y = '0;
    endcase
  end

  assign alu.eq = (alu.a == alu.b);
  assign alu.lt = $signed(alu.a) < $signed(alu.b);

endmodule

// File: rtl/kgp_risc_datapath.sv
// Single-cycle KGP-RISC core: PC, register file, IMEM/DMEM
// and program-load control around the ALU.
module kgp_risc_datapath
  import kgp_risc_datapath_pkg::*;
#(
  parameter logic signed [31:0] OP_A = 32'sd48,
  parameter logic signed [31:0] OP_B = 32'sd18,
  parameter int IMEM_DEPTH = IMEM_DEPTH_D
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem,
  output logic [31:0] alu_out,
  input  logic        pc,
  input  logic        sp,
  input  logic        gcd,
  input  logic        booth,
  input  logic        en,
  output logic [31:0] w2,
  output logic [31:0] w3
);

  localparam int PW = $clog2(IMEM_DEPTH);

  logic [PW-1:0] pc_q, pc_d, pc_br;
  logic [31:0]   rf_q   [16];
  logic [31:0]   rf_d   [16];
  logic [31:0]   dmem_q [16];
  logic [31:0]   dmem_d [16];
  logic [31:0]   imem_q [IMEM_DEPTH];
  logic [31:0]   imem_d [IMEM_DEPTH];
  logic          halt_q, halt_d;

  logic [31:0] ir, imm, rs_v, rt_v;
  logic [3:0]  rd, rs, rt;
  op_e         op;

  kgp_risc_datapath_if alu_if ();

  kgp_alu u_alu (.alu(alu_if));

  assign ir   = imem_q[pc_q];
  assign op   = op_e'(ir[OP_HI:OP_LO]);
  assign rd   = ir[RD_HI:RD_LO];
  assign rs   = ir[RS_HI:RS_LO];
  assign rt   = ir[RT_HI:RT_LO];
  assign imm  = {{16{ir[IMM_HI]}}, ir[IMM_HI:0]};
  assign rs_v = rf_q[rs];
  assign rt_v = rf_q[rt];

  always_comb begin
    alu_if.op = ALU_ADD;
    alu_if.a  = rs_v;
    alu_if.b  = rt_v;
    case (op)
      OP_SUB, OP_BEQ, OP_BLT: alu_if.op = ALU_SUB;
      OP_AND: alu_if.op = ALU_AND;
      OP_OR:  alu_if.op = ALU_OR;
      OP_XOR: alu_if.op = ALU_XOR;
      OP_SLA: alu_if.op = ALU_SLA;
      OP_SRA: alu_if.op = ALU_SRA;
      OP_ADDI, OP_LD, OP_ST: alu_if.b = imm;
      default: alu_if.op = ALU_ADD;
    endcase
  end

  assign alu_out = alu_if.y;
  assign w2      = rf_q[2];
  assign w3      = rf_q[3];
  assign pc_br   = pc_q + PW'(1) + imm[PW-1:0];

  always_comb begin
    pc_d   = pc_q;
    rf_d   = rf_q;
    dmem_d = dmem_q;
    imem_d = imem_q;
    halt_d = halt_q;
    if (pc) begin
      pc_d = '0;
    end else if (sp) begin
      rf_d[SP_REG] = SP_INIT;
    end else if (mem) begin
      dmem_d[0] = OP_A;
      dmem_d[1] = OP_B;
    end else if (gcd || booth) begin
      for (int i = 0; i < IMEM_DEPTH; i++) imem_d[i] = HALT_W;
      if (gcd) begin
        for (int i = 0; i < GCD_LEN; i++) imem_d[i] = GCD_ROM[i];
      end else begin
        for (int i = 0; i < BOOTH_LEN; i++) imem_d[i] = BOOTH_ROM[i];
      end
      halt_d = 1'b0;
    end else if (en && !halt_q) begin
      pc_d = pc_q + PW'(1);
      case (op)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
        OP_SLA, OP_SRA, OP_ADDI: rf_d[rd] = alu_if.y;
        OP_LD:  rf_d[rd] = dmem_q[alu_if.y[3:0]];
        OP_ST:  dmem_d[alu_if.y[3:0]] = rt_v;
        OP_BEQ: if (alu_if.eq) pc_d = pc_br;
        OP_BLT: if (alu_if.lt) pc_d = pc_br;
        OP_BR:  pc_d = PW'(imm[5:0]);
        OP_HALT: begin
          pc_d   = pc_q;
          halt_d = 1'b1;
        end
        default: pc_d = pc_q + PW'(1);
      endcase
    end
    // R0 is hardwired to zero
    rf_d[0] = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= '0;
      rf_q   <= '{default: '0};
      dmem_q <= '{default: '0};
      imem_q <= '{default: '0};
      halt_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      rf_q   <= rf_d;
      dmem_q <= dmem_d;
      imem_q <= imem_d;
      halt_q <= halt_d;
    end
  end

endmodule

// File: tb/tb_kgp_risc_datapath.sv
// Directed bench: four cores with different operand pairs
// run the GCD and Booth programs side by side.
module tb_kgp_risc_datapath;

  logic clk = 1'b0;
  logic rst_n, mem_p, pc_p, sp_p, gcd_p, booth_p, en;
  logic [31:0] alu_o [4];
  logic [31:0] w2    [4];
  logic [31:0] w3    [4];
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  kgp_risc_datapath #(.OP_A(32'sd48), .OP_B(32'sd18)) u0 (
    .clk(clk), .reset(rst_n), .mem(mem_p), .alu_out(alu_o[0]),
    .pc(pc_p), .sp(sp_p), .gcd(gcd_p), .booth(booth_p),
    .en(en), .w2(w2[0]), .w3(w3[0])
  );
  kgp_risc_datapath #(.OP_A(-32'sd7), .OP_B(32'sd5)) u1 (
    .clk(clk), .reset(rst_n), .mem(mem_p), .alu_out(alu_o[1]),
    .pc(pc_p), .sp(sp_p), .gcd(gcd_p), .booth(booth_p),
    .en(en), .w2(w2[1]), .w3(w3[1])
  );
  kgp_risc_datapath #(.OP_A(32'sd0), .OP_B(32'sd0)) u2 (
    .clk(clk), .reset(rst_n), .mem(mem_p), .alu_out(alu_o[2]),
    .pc(pc_p), .sp(sp_p), .gcd(gcd_p), .booth(booth_p),
    .en(en), .w2(w2[2]), .w3(w3[2])
  );
  kgp_risc_datapath #(.OP_A(32'sd17), .OP_B(32'sd0)) u3 (
    .clk(clk), .reset(rst_n), .mem(mem_p), .alu_out(alu_o[3]),
    .pc(pc_p), .sp(sp_p), .gcd(gcd_p), .booth(booth_p),
    .en(en), .w2(w2[3]), .w3(w3[3])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic g, input logic b);
    pc_p = 1'b1;  tick(1); pc_p = 1'b0;
    sp_p = 1'b1;  tick(1); sp_p = 1'b0;
    mem_p = 1'b1; tick(1); mem_p = 1'b0;
    gcd_p = g; booth_p = b; tick(1);
    gcd_p = 1'b0; booth_p = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mem_p = 1'b0; pc_p = 1'b0; sp_p = 1'b0;
    gcd_p = 1'b0; booth_p = 1'b0; en = 1'b0;
    tick(3);
    chk("rst_w2", w2[0], 32'd0);
    chk("rst_w3", w3[0], 32'd0);
    chk("rst_alu", alu_o[0], 32'd0);
    rst_n = 1'b1;
    tick(2);
    chk("idle_w2", w2[0], 32'd0);

    load(1'b1, 1'b0);
    tick(10);
    chk("hold_w2", w2[0], 32'd0);
    chk("hold_w3", w3[0], 32'd0);
    en = 1'b1;
    tick(2);
    chk("gcd_alu_u0", alu_o[0], 32'd48);
    chk("gcd_alu_u3", alu_o[3], 32'd17);
    tick(198);
    chk("gcd48_w2", w2[0], 32'd6);
    chk("gcd48_w3", w3[0], 32'd1);
    chk("gcd00_w2", w2[2], 32'd0);
    chk("gcd00_w3", w3[2], 32'd1);
    chk("gcd17_w2", w2[3], 32'd17);
    chk("gcd17_w3", w3[3], 32'd1);
    tick(20);
    chk("gcd_stable", w2[0], 32'd6);

    en = 1'b0;
    load(1'b0, 1'b1);
    en = 1'b1;
    tick(6);
    chk("bth_alu6", alu_o[0], 32'hFFFF_8000);
    en = 1'b0;
    tick(10);
    chk("frz_alu", alu_o[0], 32'hFFFF_8000);
    chk("frz_w2_u0", w2[0], 32'd18);
    chk("frz_w3_u0", w3[0], 32'd0);
    chk("frz_w2_u1", w2[1], 32'd5);
    en = 1'b1;
    tick(1);
    chk("bth_alu7", alu_o[0], 32'hFFFF_0000);
    tick(100);
    en = 1'b0;
    tick(10);
    en = 1'b1;
    tick(500);
    chk("bth864_w2", w2[0], 32'd864);
    chk("bth864_w3", w3[0], 32'd0);
    chk("bthneg_w2", w2[1], 32'hFFFF_FFDD);
    chk("bthneg_w3", w3[1], 32'hFFFF_FFFF);
    chk("bth00_w2", w2[2], 32'd0);
    chk("bth170_w3", w3[3], 32'd0);
    tick(20);
    chk("bth_stable", w2[0], 32'd864);

    en = 1'b0;
    load(1'b1, 1'b1);
    en = 1'b1;
    tick(200);
    chk("prio_w2", w2[0], 32'd6);
    chk("prio_w3", w3[0], 32'd1);

    en = 1'b0;
    load(1'b0, 1'b1);
    en = 1'b1;
    tick(50);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_w2", w2[1], 32'd0);
    chk("midrst_w3", w3[1], 32'd0);
    chk("midrst_alu", alu_o[1], 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(20);
    chk("postrst_w2", w2[0], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
